// File: rtl/measurement_gate_ctrl.sv
// Gated acquisition sequencer between the tag stream and user_sample.
// Opens trigger-started time windows, masks lanes outside them and tracks run progress.
module measurement_gate_ctrl #(
  parameter int WORD_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic [64*WORD_WIDTH-1:0]       s_axis_tagtime,
  input  logic signed [6*WORD_WIDTH-1:0] s_axis_channel,
  input  logic [WORD_WIDTH-1:0]          s_axis_tkeep,
  output logic                           m_axis_tvalid,
  output logic [64*WORD_WIDTH-1:0]       m_axis_tagtime,
  output logic signed [6*WORD_WIDTH-1:0] m_axis_channel,
  output logic [WORD_WIDTH-1:0]          m_axis_tkeep,
  input  logic                           cfg_start,
  input  logic                           cfg_abort,
  input  logic signed [5:0]              cfg_trig_channel,
  input  logic [63:0]                    cfg_window,
  input  logic [15:0]                    cfg_num_windows,
  output logic                           busy,
  output logic                           done,
  output logic [15:0]                    windows_done,
  output logic [31:0]                    tags_passed
);

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

  state_t                 state, state_next;
  logic signed [5:0]      trig;
  logic [63:0]            window;
  logic [15:0]            num_windows;
  logic [63:0]            t_end, t_end_next;
  logic [15:0]            wd_next;
  logic [31:0]            tags_next;
  logic                   done_next;
  logic [WORD_WIDTH-1:0]  pass;
  logic [WORD_WIDTH-1:0]  from_trig;
  logic                   seen;
  logic                   close;
  logic [63:0]            trig_t;
  logic [63:0]            cand_end;
  logic [32:0]            sum;

  assign s_axis_tready = 1'b1;

  always_comb begin
    state_next = state;
    t_end_next = t_end;
    wd_next    = windows_done;
    tags_next  = tags_passed;
    done_next  = 1'b0;
    pass       = '0;
    close      = 1'b0;
    seen       = 1'b0;
    trig_t     = '0;
    from_trig  = '0;
    sum        = '0;

    // from_trig marks the trigger lane and every lane after it
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (!seen && s_axis_tkeep[i] && (s_axis_channel[6*i +: 6] == trig)) begin
        seen   = 1'b1;
        trig_t = s_axis_tagtime[64*i +: 64];
      end
      from_trig[i] = seen;
    end
    cand_end = trig_t + window;

    if (cfg_abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start) begin
            state_next = ARMED;
            wd_next    = '0;
            tags_next  = '0;
          end
        end
        ARMED: begin
          if (s_axis_tvalid && seen) begin
            for (int i = 0; i < WORD_WIDTH; i++) begin
              if (from_trig[i] && s_axis_tkeep[i]) begin
                if (s_axis_tagtime[64*i +: 64] < cand_end) pass[i] = 1'b1;
                else                                       close   = 1'b1;
              end
            end
            if (!close) begin
              state_next = ACTIVE;
              t_end_next = cand_end;
            end
          end
        end
        ACTIVE: begin
          if (s_axis_tvalid) begin
            for (int i = 0; i < WORD_WIDTH; i++) begin
              if (s_axis_tkeep[i]) begin
                if (s_axis_tagtime[64*i +: 64] < t_end) pass[i] = 1'b1;
                else                                    close   = 1'b1;
              end
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // A close re-arms for the next word, so triggers in the closing word are ignored
    if (close) begin
      wd_next = windows_done + 16'd1;
      if (wd_next == num_windows) begin
        state_next = IDLE;
        done_next  = 1'b1;
      end else begin
        state_next = ARMED;
      end
    end

    sum = {1'b0, tags_next};
    for (int i = 0; i < WORD_WIDTH; i++) begin
      sum = sum + {32'd0, pass[i]};
    end
    tags_next = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      trig           <= '0;
      window         <= '0;
      num_windows    <= '0;
      t_end          <= '0;
      windows_done   <= '0;
      tags_passed    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tagtime <= '0;
      m_axis_channel <= '0;
      m_axis_tkeep   <= '0;
    end else begin
      state          <= state_next;
      t_end          <= t_end_next;
      windows_done   <= wd_next;
      tags_passed    <= tags_next;
      busy           <= (state_next != IDLE);
      done           <= done_next;
      m_axis_tvalid  <= s_axis_tvalid;
      m_axis_tagtime <= s_axis_tagtime;
      m_axis_channel <= s_axis_channel;
      m_axis_tkeep   <= s_axis_tkeep & pass;
      if (state == IDLE && cfg_start && !cfg_abort) begin
        trig        <= cfg_trig_channel;
        window      <= cfg_window;
        num_windows <= (cfg_num_windows == 16'd0) ? 16'd1 : cfg_num_windows;
      end
    end
  end

endmodule
